pipo_register: RTL and testbench



---
 rtl/pipo_pkg.sv | 16 +
 rtl/pipo_stage.sv | 31 +++
 rtl/pipo_register.sv | 76 +++++++
 tb/tb_pipo_register.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipo_pkg.sv
// Shared constants, word type and parity helper for the pipo_register slice.
// pipo_parity is only referenced when PIPO_REGISTER_PARITY_EN is defined.
package pipo_pkg;

    localparam int PIPO_DEF_WIDTH  = 32;
    localparam int PIPO_MAX_STAGES = 16;
    localparam int PIPO_MAX_WIDTH  = 1024;

    typedef logic [PIPO_DEF_WIDTH-1:0] pipo_word_t;

    // Callers zero-extend narrower words; the extra zeros leave the parity unchanged.
    function automatic logic pipo_parity(input logic [PIPO_MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/pipo_stage.sv
// One WIDTH-bit register stage with asynchronous active-low reset to RESET_VALUE.
module pipo_stage
    import pipo_pkg::*;
#(
    parameter int               WIDTH       = PIPO_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_d;
    logic [WIDTH-1:0] stage_q;

    always_comb begin
        stage_d = d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= RESET_VALUE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/pipo_register.sv
// Parallel-in/parallel-out register of STAGES cascaded pipo_stage flops.
// Optional registered even-parity output so_par under macro PIPO_REGISTER_PARITY_EN.
module pipo_register
    import pipo_pkg::*;
#(
    parameter int               WIDTH       = PIPO_DEF_WIDTH,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] si,
`ifdef PIPO_REGISTER_PARITY_EN
    output logic [WIDTH-1:0] so,
    output logic             so_par
`else
    output logic [WIDTH-1:0] so
`endif
);

    if (WIDTH < 1 || WIDTH > PIPO_MAX_WIDTH) begin : g_bad_width
        $error("pipo_register: WIDTH=%0d outside 1..%0d", WIDTH, PIPO_MAX_WIDTH);
    end
    if (STAGES < 1 || STAGES > PIPO_MAX_STAGES) begin : g_bad_stages
        $error("pipo_register: STAGES=%0d outside 1..%0d", STAGES, PIPO_MAX_STAGES);
    end

    logic [WIDTH-1:0] stage_d [STAGES];
    logic [WIDTH-1:0] stage_q [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_d[k] = si;
        end else begin : g_next
            assign stage_d[k] = stage_q[k-1];
        end

        pipo_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d   (stage_d[k]),
            .q   (stage_q[k])
        );
    end

    assign so = stage_q[STAGES-1];

`ifdef PIPO_REGISTER_PARITY_EN
    // Parity is computed from the final stage's input so it lands on the same edge as so.
    localparam logic SO_PAR_RESET = ^RESET_VALUE;

    logic [PIPO_MAX_WIDTH-1:0] par_word;
    logic                      so_par_d;
    logic                      so_par_q;

    always_comb begin
        par_word             = '0;
        par_word[WIDTH-1:0]  = stage_d[STAGES-1];
        so_par_d             = pipo_parity(par_word);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            so_par_q <= SO_PAR_RESET;
        end else begin
            so_par_q <= so_par_d;
        end
    end

    assign so_par = so_par_q;
`endif

endmodule

// File: tb/tb_pipo_register.sv
// Directed bench for pipo_register: default, STAGES=3 and non-zero RESET_VALUE instances.
module tb_pipo_register;

    logic        clk;
    logic        rst;
    logic        rst_rv;
    logic [31:0] si;
    logic [31:0] so;
    logic [31:0] so3;
    logic [31:0] so_rv;
`ifdef PIPO_REGISTER_PARITY_EN
    logic        so_par;
    logic        so_par3;
    logic        so_par_rv;
`endif

    int n_tests;
    int n_fail;

    pipo_register dut (
        .clk (clk),
        .rst (rst),
        .si  (si),
`ifdef PIPO_REGISTER_PARITY_EN
        .so_par (so_par),
`endif
        .so  (so)
    );

    pipo_register #(.STAGES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .si  (si),
`ifdef PIPO_REGISTER_PARITY_EN
        .so_par (so_par3),
`endif
        .so  (so3)
    );

    pipo_register #(.RESET_VALUE(32'hCAFEF00D)) dut_rv (
        .clk (clk),
        .rst (rst_rv),
        .si  (si),
`ifdef PIPO_REGISTER_PARITY_EN
        .so_par (so_par_rv),
`endif
        .so  (so_rv)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [31:0] val);
        @(negedge clk);
        si = val;
        @(posedge clk);
        #10;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        rst_rv  = 1'b1;
        si      = 32'h0;
        #5 rst_rv = 1'b0;
        #1 check("rv_async_assert", so_rv, 32'hCAFEF00D);

        @(posedge clk); #10;
        check("first_capture_zero", so, 32'h0);
        step(32'h6608dc4d);
        check("capture_6608dc4d", so, 32'h6608dc4d);
        check("rv_held_1", so_rv, 32'hCAFEF00D);

        #40 rst = 1'b0;
        #1;
        check("async_reset_immediate", so, 32'h0);
        check("async_reset_s3", so3, 32'h0);
        @(posedge clk); #10;
        check("reset_held_1", so, 32'h0);
        step(32'h55555555);
        check("reset_held_2", so, 32'h0);
        check("rv_held_2", so_rv, 32'hCAFEF00D);

        @(negedge clk);
        rst = 1'b1;
        si  = 32'h00000001;
        @(posedge clk); #10;
        check("stream_1", so, 32'h00000001);
        check("s3_after_release_1", so3, 32'h0);
        step(32'hFFFFFFFF);
        check("stream_ffffffff", so, 32'hFFFFFFFF);
        check("s3_after_release_2", so3, 32'h0);
        step(32'hA5A5A5A5);
        check("stream_a5a5a5a5", so, 32'hA5A5A5A5);
        check("s3_first_word", so3, 32'h00000001);
        check("rv_held_3", so_rv, 32'hCAFEF00D);

        step(32'hDEADBEEF);
        check("pre_pulse", so, 32'hDEADBEEF);
        check("s3_pre_pulse", so3, 32'hFFFFFFFF);
        #10 rst = 1'b0;
        #1;
        check("pulse_reset", so, 32'h0);
        check("pulse_reset_s3", so3, 32'h0);
        #9 rst = 1'b1;
        #1;
        check("pulse_release_no_edge", so, 32'h0);
        step(32'h13572468);
        check("after_pulse", so, 32'h13572468);

        for (int i = 0; i < 3; i++) step(32'h0);
        step(32'h12345678);
        check("s3_edge1", so3, 32'h0);
        step(32'h0);
        check("s3_edge2", so3, 32'h0);
        step(32'h0);
        check("s3_edge3", so3, 32'h12345678);
        step(32'h0);
        check("s3_edge4", so3, 32'h0);
        check("rv_held_4", so_rv, 32'hCAFEF00D);

`ifdef PIPO_REGISTER_PARITY_EN
        check("par_rv_reset", {31'b0, so_par_rv}, 32'h0);
        step(32'h00000007);
        check("par_7", {31'b0, so_par}, 32'h1);
        @(negedge clk);
        si = 32'h00000003;
        #1;
        check("par_before_edge", {31'b0, so_par}, 32'h1);
        @(posedge clk); #10;
        check("par_3", {31'b0, so_par}, 32'h0);
        check("par_3_so", so, 32'h00000003);
`endif

        @(negedge clk);
        si     = 32'h0BADF00D;
        rst_rv = 1'b1;
        #1;
        check("rv_release_no_edge", so_rv, 32'hCAFEF00D);
        @(posedge clk); #10;
        check("rv_release_capture", so_rv, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
